md_ctrl: RTL and testbench

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/mips_pkg.sv | 26 ++
 rtl/md_counter.sv | 36 +++
 rtl/md_ctrl.sv | 136 +++++++++++++
 tb/tb_md_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings and defaults for the multiply/divide controller.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 8;

  function automatic logic is_long_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_counter.sv
// Loadable down-counter; holds at zero and flags terminal count.
module md_counter
  import mips_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         count_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (count_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide unit controller: IDLE/BUSY sequencing, HI/LO registers, pipeline stall.
// state | meaning
// IDLE  | accepts MULT/DIV (go BUSY) and MTHI/MTLO (write at once)
// BUSY  | counting down; results in pending regs, committed on terminal count
module md_ctrl
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        id_uses_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // The counter runs N-1 .. 0, giving exactly N busy cycles.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e   state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
  logic        cnt_load, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  logic        mul_sgn, div_sgn, a_neg, b_neg;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  always_comb begin
    mul_sgn = (op == OP_MULT);
    div_sgn = (op == OP_DIV);
    a_ext   = {{32{mul_sgn & a[31]}}, a};
    b_ext   = {{32{mul_sgn & b[31]}}, b};
    prod    = a_ext * b_ext;
    // Magnitude divide avoids the signed-overflow corner (0x80000000 / -1).
    a_neg   = div_sgn & a[31];
    b_neg   = div_sgn & b[31];
    a_mag   = a_neg ? (~a + 32'd1) : a;
    b_mag   = b_neg ? (~b + 32'd1) : b;
    b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / b_safe;
    r_mag   = a_mag % b_safe;
    quo     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem     = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_d                = ST_BUSY;
              {pend_hi_d, pend_lo_d} = prod;
              pend_wr_d              = 1'b1;
              cnt_load               = 1'b1;
              cnt_val                = MULT_LOAD;
            end
            OP_DIV, OP_DIVU: begin
              state_d   = ST_BUSY;
              pend_hi_d = rem;
              pend_lo_d = quo;
              pend_wr_d = (b != 32'd0);
              cnt_load  = 1'b1;
              cnt_val   = DIV_LOAD;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  md_counter #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .count_i    (state_q == ST_BUSY),
    .zero_o     (cnt_zero)
  );

  assign busy  = (state_q == ST_BUSY);
  assign stall = id_uses_md & (busy | (start & is_long_op(op)));
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Randomised scoreboard bench for md_ctrl against a longint arithmetic reference model.
module tb_md_ctrl;
  import mips_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, id_uses_md;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, stall;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .id_uses_md (id_uses_md),
    .busy       (busy),
    .stall      (stall),
    .hi         (hi),
    .lo         (lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference model: architectural effect of one accepted instruction.
  task automatic model_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          output int len);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(av));
    sb  = longint'($signed(bv));
    len = 0;
    case (o)
      3'd0: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; len = MC; end
      3'd1: begin p = {32'd0, av} * {32'd0, bv}; hi_m = p[63:32]; lo_m = p[31:0]; len = MC; end
      3'd2: begin
        len = DC;
        if (bv != 32'd0) begin q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0]; end
      end
      3'd3: begin
        len = DC;
        if (bv != 32'd0) begin lo_m = av / bv; hi_m = av % bv; end
      end
      3'd4: hi_m = av;
      3'd5: lo_m = av;
      default: ;
    endcase
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input bit idu, input bit poke);
    int   len;
    exp_t e;
    bit   done;
    start = 1'b1; op = o; a = av; b = bv; id_uses_md = idu;
    model_op(o, av, bv, len);
    if (len > 0) begin
      e.hi = hi_m; e.lo = lo_m; e.len = len;
      sb_q.push_back(e);
    end
    #1;
    chk1("stall_start", stall, idu && (len > 0));
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    if (len == 0) begin
      chk1("busy_noop", busy, 1'b0);
      chk("hi_direct", hi, hi_m);
      chk("lo_direct", lo, lo_m);
    end else begin
      done = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
        if (!busy) begin
          done = 1'b1;
        end else begin
          chk1("stall_busy", stall, idu);
          if (poke && k == 1) begin
            start = 1'b1; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
          end else begin
            start = 1'b0;
          end
          @(posedge clk); #1;
        end
      end
      start = 1'b0;
      if (!done) begin
        checks++; errors++;
        $display("FAIL busy_timeout: busy still %b after 60 cycles, required 0", busy);
      end
      chk1("stall_after", stall, 1'b0);
    end
  endtask

  // Monitor: each busy->idle transition presents a result to compare.
  initial begin
    int   bcnt;
    bit   prev;
    exp_t e;
    bcnt = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bcnt = 0; prev = 1'b0;
      end else begin
        if (busy) begin
          bcnt++;
        end else if (prev) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_unexpected: result after %0d busy cycles, required none", bcnt);
          end else begin
            e = sb_q.pop_front();
            chk("sb_hi", hi, e.hi);
            chk("sb_lo", lo, e.lo);
            chk("sb_len", 32'(bcnt), 32'(e.len));
          end
          bcnt = 0;
        end
        prev = busy;
      end
    end
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; id_uses_md = 1'b0;
    #2;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    do_op(OP_MULT, 32'd3, 32'hFFFF_FFFE, 1'b0, 1'b0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'h0000_0001);
    do_op(OP_DIVU, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    chk("divu_lo", lo, 32'd0);
    chk("divu_hi", hi, 32'd7);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    do_op(OP_MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    do_op(OP_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
    do_op(OP_DIVU, $urandom, 32'd0, 1'b0, 1'b0);
    chk("dz_hi", hi, 32'h1234_5678);
    chk("dz_lo", lo, 32'hCAFE_F00D);

    do_op(OP_MULTU, $urandom, $urandom, 1'b1, 1'b1);
    id_uses_md = 1'b0;
    do_op(3'd6, $urandom, $urandom, 1'b0, 1'b0);
    do_op(3'd7, $urandom, $urandom, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      do_op(ro, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    do_op(OP_MULT, 32'h1234, 32'h5678, 1'b0, 1'b0);
    start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7; id_uses_md = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk1("pre_rst_busy", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk1("async_rst_busy", busy, 1'b0);
    chk1("async_rst_stall", stall, 1'b0);
    chk("async_rst_hi", hi, 32'd0);
    chk("async_rst_lo", lo, 32'd0);
    hi_m = 32'd0; lo_m = 32'd0;
    id_uses_md = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    do_op(OP_MULT, 32'd2, 32'd2, 1'b0, 1'b0);
    chk("post_rst_lo", lo, 32'd4);
    chk("post_rst_hi", hi, 32'd0);

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
